// File: rtl/sat_pkg.sv
// Shared types for the SAT implication datapath.
//   VAR_W               : width of a variable index
//   imply_entry_t       : one implication {val, variable}
//   imply_ctrl_state_e  : sequencing state of imply_stack_ctrl
package sat_pkg;

  localparam int VAR_W = 9;

  typedef struct packed {
    logic             val;
    logic [VAR_W-1:0] variable;
  } imply_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } imply_ctrl_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Grants the first asserted request at or after the internal pointer,
// searching modulo NUM_REQ. The pointer moves to one past the winner, and
// only when a grant is actually issued (en=1 and some request set).
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   en         : grant permission for this cycle
//   req        : request vector
//   grant      : one-hot grant (combinational), all zero when en=0
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned N     = NUM_REQ;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] sel;
  logic             found;
  int unsigned      idx;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      sel = PTR_W'(idx);
      if (en && !found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
        ptr_d      = PTR_W'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/imply_stack_ctrl.sv
// Sequencing / arbitration controller in front of imply_stack.
// Sole master of the stack: accepts implications from NUM_REQ clause units
// through a round-robin arbiter, serves pops to the BCP engine and clears
// the stack on a conflict flush. Keeps the authoritative occupancy count.
// Per cycle in RUN: flush > pop > push, at most one stack operation.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/val/var : push requests, var slice i = [i*VAR_W +: VAR_W]
//   req_grant         : one-hot push grant (combinational)
//   pop_req           : BCP engine pop request
//   pop_valid/val/var : registered pop result, one cycle after pop_req
//   flush             : discard all pending implications
//   count/empty/full  : registered occupancy and flags
//   busy              : state is FLUSH
//   underflow         : sticky, pop_req while empty
//   stk_*             : stack control / data (en, reset, rw, val, variable)
//   stk_val_out/stk_variable_out : top-of-stack data from the stack
module imply_stack_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int VAR_W   = 9,
  parameter int DEPTH   = 128,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_val,
  input  logic [NUM_REQ*VAR_W-1:0] req_var,
  output logic [NUM_REQ-1:0]       req_grant,
  input  logic                     pop_req,
  output logic                     pop_valid,
  output logic                     pop_val,
  output logic [VAR_W-1:0]         pop_var,
  input  logic                     flush,
  output logic [CNT_W-1:0]         count,
  output logic                     empty,
  output logic                     full,
  output logic                     busy,
  output logic                     underflow,
  output logic                     stk_en,
  output logic                     stk_reset,
  output logic                     stk_rw,
  output logic                     stk_val,
  output logic [VAR_W-1:0]         stk_variable,
  input  logic                     stk_val_out,
  input  logic [VAR_W-1:0]         stk_variable_out
);

  import sat_pkg::*;

  imply_ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_valid_q, pop_valid_d;
  imply_entry_t      pop_q, pop_d;
  logic              underflow_q, underflow_d;

  logic               empty_w, full_w;
  logic               pop_go;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  imply_entry_t       push_entry;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign pop_go  = pop_req && !empty_w;

  // Arbiter permission is computed outside the FSM process so the grant
  // feeding the FSM does not form a combinational loop through it.
  assign arb_en = !reset && (state_q == RUN) && !flush && !pop_go && !full_w;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (req_valid),
    .grant (grant)
  );

  // Data of the granted requester (grant is one-hot or zero).
  always_comb begin
    push_entry = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        push_entry.val      = req_val[i];
        push_entry.variable = req_var[i*VAR_W +: VAR_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pop_valid_d  = 1'b0;
    pop_d        = pop_q;
    underflow_d  = underflow_q;
    stk_en       = 1'b0;
    stk_reset    = 1'b0;
    stk_rw       = 1'b0;
    stk_val      = 1'b0;
    stk_variable = '0;
    if (reset) begin
      // Clear the stack in the same cycle reset is held.
      stk_en    = 1'b1;
      stk_reset = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (flush) begin
            state_d = FLUSH;
          end else if (pop_go) begin
            stk_en         = 1'b1;
            stk_rw         = 1'b0;
            count_d        = count_q - CNT_W'(1);
            pop_valid_d    = 1'b1;
            pop_d.val      = stk_val_out;
            pop_d.variable = stk_variable_out;
          end else begin
            if (pop_req) begin
              underflow_d = 1'b1;
            end
            if (|grant) begin
              stk_en       = 1'b1;
              stk_rw       = 1'b1;
              stk_val      = push_entry.val;
              stk_variable = push_entry.variable;
              count_d      = count_q + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          stk_en    = 1'b1;
          stk_reset = 1'b1;
          count_d   = '0;
          state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      pop_q       <= pop_d;
      underflow_q <= underflow_d;
    end
  end

  assign req_grant = grant;
  assign pop_valid = pop_valid_q;
  assign pop_val   = pop_q.val;
  assign pop_var   = pop_q.variable;
  assign count     = count_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign busy      = (state_q != RUN);
  assign underflow = underflow_q;

endmodule

// File: tb/tb_imply_stack_ctrl.sv
// Directed bench for imply_stack_ctrl with a small LIFO model standing in
// for imply_stack (top of stack presented combinationally on *_out).
module tb_imply_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_val;
  logic [35:0] req_var;
  logic [3:0]  req_grant;
  logic        pop_req, pop_valid, pop_val;
  logic [8:0]  pop_var;
  logic        flush;
  logic [7:0]  count;
  logic        empty, full, busy, underflow;
  logic        stk_en, stk_reset, stk_rw, stk_val;
  logic [8:0]  stk_variable;
  logic        stk_val_out;
  logic [8:0]  stk_variable_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imply_stack_ctrl #(.NUM_REQ(4), .VAR_W(9), .DEPTH(128)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_val(req_val), .req_var(req_var),
    .req_grant(req_grant),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_val(pop_val), .pop_var(pop_var),
    .flush(flush), .count(count), .empty(empty), .full(full), .busy(busy),
    .underflow(underflow),
    .stk_en(stk_en), .stk_reset(stk_reset), .stk_rw(stk_rw), .stk_val(stk_val),
    .stk_variable(stk_variable),
    .stk_val_out(stk_val_out), .stk_variable_out(stk_variable_out)
  );

  // Stack model
  logic [9:0] smem [0:255];
  logic [7:0] sp = 8'd0;
  always @(posedge clk) begin
    if (stk_en) begin
      if (stk_reset) sp <= 8'd0;
      else if (stk_rw) begin
        smem[sp] <= {stk_val, stk_variable};
        sp <= sp + 8'd1;
      end else if (sp != 8'd0) sp <= sp - 8'd1;
    end
  end
  assign stk_val_out      = (sp != 8'd0) ? smem[sp - 8'd1][9]   : 1'b0;
  assign stk_variable_out = (sp != 8'd0) ? smem[sp - 8'd1][8:0] : 9'd0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req_valid = '0; req_val = '0; req_var = '0;
    pop_req = 1'b0; flush = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 4'b1111; req_val = '0; req_var = '0;
    pop_req = 1'b0; flush = 1'b0;
    #1;
    if (stk_en !== 1'b1 || stk_reset !== 1'b1) begin bad++; $display("FAIL rst_stk got en=%b rst=%b exp 1 1", stk_en, stk_reset); end total++;
    if (req_grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b exp=0000", req_grant); end total++;
    tick; tick;
    req_valid = '0; reset = 1'b0; #1;
    if (count !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end total++;
    if (pop_valid !== 1'b0 || pop_var !== 9'd0 || pop_val !== 1'b0) begin bad++; $display("FAIL rst_pop got v=%b var=%0d val=%b exp 0 0 0", pop_valid, pop_var, pop_val); end total++;
    if (underflow !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_flags got uf=%b e=%b f=%b b=%b exp 0 1 0 0", underflow, empty, full, busy); end total++;
    if (stk_en !== 1'b0) begin bad++; $display("FAIL rst_idle got en=%b exp=0", stk_en); end total++;
  endtask

  task automatic test_basic;
    do_reset;
    req_valid = 4'b0101; req_val = 4'b0001;
    req_var[8:0] = 9'd5; req_var[26:18] = 9'd9;
    #1;
    if (req_grant !== 4'b0001) begin bad++; $display("FAIL basic_g0 got=%b exp=0001", req_grant); end total++;
    if (stk_en !== 1'b1 || stk_rw !== 1'b1 || stk_val !== 1'b1 || stk_variable !== 9'd5) begin bad++; $display("FAIL basic_w0 got en=%b rw=%b val=%b var=%0d exp 1 1 1 5", stk_en, stk_rw, stk_val, stk_variable); end total++;
    tick;
    req_valid = 4'b0100; #1;
    if (req_grant !== 4'b0100) begin bad++; $display("FAIL basic_g1 got=%b exp=0100", req_grant); end total++;
    if (stk_val !== 1'b0 || stk_variable !== 9'd9) begin bad++; $display("FAIL basic_w1 got val=%b var=%0d exp 0 9", stk_val, stk_variable); end total++;
    tick;
    req_valid = 4'b0000;
    if (count !== 8'd2) begin bad++; $display("FAIL basic_cnt2 got=%0d exp=2", count); end total++;
    pop_req = 1'b1; #1;
    if (stk_en !== 1'b1 || stk_rw !== 1'b0) begin bad++; $display("FAIL basic_popop got en=%b rw=%b exp 1 0", stk_en, stk_rw); end total++;
    tick;
    if (pop_valid !== 1'b1 || pop_var !== 9'd9 || pop_val !== 1'b0) begin bad++; $display("FAIL basic_pop1 got v=%b var=%0d val=%b exp 1 9 0", pop_valid, pop_var, pop_val); end total++;
    tick;
    if (pop_valid !== 1'b1 || pop_var !== 9'd5 || pop_val !== 1'b1) begin bad++; $display("FAIL basic_pop2 got v=%b var=%0d val=%b exp 1 5 1", pop_valid, pop_var, pop_val); end total++;
    if (count !== 8'd0 || empty !== 1'b1) begin bad++; $display("FAIL basic_empty got cnt=%0d e=%b exp 0 1", count, empty); end total++;
    #1;
    if (stk_en !== 1'b0) begin bad++; $display("FAIL basic_noacc got en=%b exp=0", stk_en); end total++;
    tick;
    pop_req = 1'b0;
    if (pop_valid !== 1'b0 || underflow !== 1'b1) begin bad++; $display("FAIL basic_uf got v=%b uf=%b exp 0 1", pop_valid, underflow); end total++;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    do_reset;
    req_valid = 4'b1111; req_val = 4'b1010; req_var = {9'd4, 9'd3, 9'd2, 9'd1};
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_g = 4'b0001 << (k % 4);
      if (req_grant !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_grant, exp_g); end total++;
      tick;
    end
    req_valid = '0;
    if (count !== 8'd8) begin bad++; $display("FAIL rr_count got=%0d exp=8", count); end total++;
  endtask

  task automatic test_full;
    do_reset;
    req_valid = 4'b0001; req_val = 4'b0001; req_var = '0; req_var[8:0] = 9'd7;
    for (int k = 0; k < 128; k++) tick;
    if (count !== 8'd128 || full !== 1'b1) begin bad++; $display("FAIL full_set got cnt=%0d f=%b exp 128 1", count, full); end total++;
    #1;
    if (req_grant !== 4'b0000 || stk_en !== 1'b0) begin bad++; $display("FAIL full_nogrant got g=%b en=%b exp 0000 0", req_grant, stk_en); end total++;
    pop_req = 1'b1; #1;
    if (req_grant !== 4'b0000 || stk_en !== 1'b1 || stk_rw !== 1'b0) begin bad++; $display("FAIL full_pop got g=%b en=%b rw=%b exp 0000 1 0", req_grant, stk_en, stk_rw); end total++;
    tick;
    pop_req = 1'b0;
    if (pop_valid !== 1'b1 || pop_var !== 9'd7 || count !== 8'd127 || full !== 1'b0) begin bad++; $display("FAIL full_popres got v=%b var=%0d cnt=%0d f=%b exp 1 7 127 0", pop_valid, pop_var, count, full); end total++;
    #1;
    if (req_grant !== 4'b0001 || stk_rw !== 1'b1) begin bad++; $display("FAIL full_refill got g=%b rw=%b exp 0001 1", req_grant, stk_rw); end total++;
    tick;
    if (count !== 8'd128 || full !== 1'b1) begin bad++; $display("FAIL full_again got cnt=%0d f=%b exp 128 1", count, full); end total++;
    #1;
    if (req_grant !== 4'b0000) begin bad++; $display("FAIL full_once got=%b exp=0000", req_grant); end total++;
    req_valid = '0;
  endtask

  task automatic test_pop_vs_push;
    do_reset;
    req_valid = 4'b0001; req_val = '0;
    for (int k = 1; k <= 3; k++) begin
      req_var[8:0] = 9'(k);
      tick;
    end
    req_valid = 4'b0010; req_var[17:9] = 9'd20; pop_req = 1'b1; #1;
    if (req_grant !== 4'b0000 || stk_en !== 1'b1 || stk_rw !== 1'b0) begin bad++; $display("FAIL pvp_pop got g=%b en=%b rw=%b exp 0000 1 0", req_grant, stk_en, stk_rw); end total++;
    tick;
    pop_req = 1'b0;
    if (pop_valid !== 1'b1 || pop_var !== 9'd3 || count !== 8'd2) begin bad++; $display("FAIL pvp_res got v=%b var=%0d cnt=%0d exp 1 3 2", pop_valid, pop_var, count); end total++;
    #1;
    if (req_grant !== 4'b0010 || stk_variable !== 9'd20) begin bad++; $display("FAIL pvp_push got g=%b var=%0d exp 0010 20", req_grant, stk_variable); end total++;
    tick;
    req_valid = '0;
    if (count !== 8'd3) begin bad++; $display("FAIL pvp_cnt got=%0d exp=3", count); end total++;
  endtask

  task automatic test_flush;
    do_reset;
    req_valid = 4'b0001; req_val = '0;
    for (int k = 0; k < 10; k++) begin
      req_var[8:0] = 9'(k + 100);
      tick;
    end
    if (count !== 8'd10) begin bad++; $display("FAIL fl_pre got=%0d exp=10", count); end total++;
    flush = 1'b1; pop_req = 1'b1; #1;
    if (req_grant !== 4'b0000 || stk_en !== 1'b0) begin bad++; $display("FAIL fl_run got g=%b en=%b exp 0000 0", req_grant, stk_en); end total++;
    tick;
    pop_req = 1'b0;
    if (busy !== 1'b1 || pop_valid !== 1'b0 || count !== 8'd10) begin bad++; $display("FAIL fl_state got b=%b v=%b cnt=%0d exp 1 0 10", busy, pop_valid, count); end total++;
    #1;
    if (stk_en !== 1'b1 || stk_reset !== 1'b1 || req_grant !== 4'b0000) begin bad++; $display("FAIL fl_clear got en=%b rst=%b g=%b exp 1 1 0000", stk_en, stk_reset, req_grant); end total++;
    tick;
    flush = 1'b0;
    if (busy !== 1'b0 || count !== 8'd0 || empty !== 1'b1 || pop_valid !== 1'b0) begin bad++; $display("FAIL fl_done got b=%b cnt=%0d e=%b v=%b exp 0 0 1 0", busy, count, empty, pop_valid); end total++;
    #1;
    if (req_grant !== 4'b0001 || stk_reset !== 1'b0) begin bad++; $display("FAIL fl_resume got g=%b rst=%b exp 0001 0", req_grant, stk_reset); end total++;
    tick;
    req_valid = '0;
    if (count !== 8'd1) begin bad++; $display("FAIL fl_cnt1 got=%0d exp=1", count); end total++;
  endtask

  task automatic test_reset_mid;
    do_reset;
    pop_req = 1'b1; tick; pop_req = 1'b0;
    if (underflow !== 1'b1) begin bad++; $display("FAIL rm_uf got=%b exp=1", underflow); end total++;
    req_valid = 4'b0001; req_var[8:0] = 9'd33; tick; tick; req_valid = '0;
    flush = 1'b1; tick; flush = 1'b0;
    if (busy !== 1'b1) begin bad++; $display("FAIL rm_inflush got=%b exp=1", busy); end total++;
    reset = 1'b1; #1;
    if (stk_en !== 1'b1 || stk_reset !== 1'b1) begin bad++; $display("FAIL rm_stk1 got en=%b rst=%b exp 1 1", stk_en, stk_reset); end total++;
    tick;
    reset = 1'b0;
    if (busy !== 1'b0 || count !== 8'd0 || underflow !== 1'b0 || pop_valid !== 1'b0) begin bad++; $display("FAIL rm_after1 got b=%b cnt=%0d uf=%b v=%b exp 0 0 0 0", busy, count, underflow, pop_valid); end total++;
    req_valid = 4'b0001; req_val = 4'b0001; req_var[8:0] = 9'd44; tick; tick; req_valid = '0;
    if (count !== 8'd2) begin bad++; $display("FAIL rm_cnt2 got=%0d exp=2", count); end total++;
    pop_req = 1'b1; reset = 1'b1; #1;
    if (stk_reset !== 1'b1) begin bad++; $display("FAIL rm_stk2 got=%b exp=1", stk_reset); end total++;
    tick;
    reset = 1'b0; pop_req = 1'b0;
    if (pop_valid !== 1'b0 || pop_var !== 9'd0 || pop_val !== 1'b0 || count !== 8'd0 || empty !== 1'b1) begin bad++; $display("FAIL rm_after2 got v=%b var=%0d val=%b cnt=%0d e=%b exp 0 0 0 0 1", pop_valid, pop_var, pop_val, count, empty); end total++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_full;
    test_pop_vs_push;
    test_flush;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
